rf_port_arbiter: RTL and testbench
==================================

Name: rf_port_arbiter

Overview:
- Shares the 8x32 register file between two independent requesters, A (index 0) and B (index 1).
- Each requester issues one read or one write per handshake.
- The arbiter drives the register file write port (we/wAddr/wData) and read port (rAddr), and returns registered read data.
- Allows dual issue (one write plus one read per cycle) when the two requesters want different ports; otherwise it arbitrates round-robin.

Parameters:
DATA_W, 32, data width; must match the register file.
ADDR_W, 3, address width; 2**ADDR_W registers.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_we  input  1  1 = write, 0 = read
req0_addr  input  ADDR_W  target register
req0_wdata  input  DATA_W  write data; ignored for reads
req0_ready  output  1  requester 0 operation accepted this cycle
rsp0_valid  output  1  read data valid for requester 0
rsp0_rdata  output  DATA_W  read data for requester 0
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
rf_we  output  1  register file write enable
rf_wAddr  output  ADDR_W  register file write address
rf_wData  output  DATA_W  register file write data
rf_rAddr  output  ADDR_W  register file read address
rf_rData  input  DATA_W  register file read data (combinational from rf_rAddr)

Behaviour:
- Handshake: an operation transfers when reqN_valid && reqN_ready at a rising edge. reqN_ready is combinational from the valids, op types and rr_ptr. Requesters hold valid and payload stable until accepted.
- Single valid: that requester gets ready=1 in the same cycle.
- Both valid, different op types: both get ready=1. The write goes to the write port and the read goes to the read port in the same cycle.
- Both valid, same op type: only the requester selected by rr_ptr gets ready=1.
  - After a contended grant, rr_ptr <= index of the loser.
  - rr_ptr is unchanged on uncontended or dual-issue cycles.
  - Reset value of rr_ptr is 0 (requester 0 has priority first).
- Write path: in a write-grant cycle, rf_we=1 and rf_wAddr/rf_wData = the winner's addr/wdata. The register file commits at that edge.
  - With no write grant: rf_we=0, rf_wAddr=0, rf_wData=0.
- Read path: in a read-grant cycle, rf_rAddr = the winner's addr; otherwise rf_rAddr=0. At the edge, rf_rData is captured into the winner's rsp register.
  - rspN_valid=1 for exactly one cycle, the cycle after acceptance (latency 1).
  - Back-to-back reads produce back-to-back rsp pulses.
- Same-cycle bypass: on a dual-issue cycle where the read addr equals the write addr, the read response returns the write data, not rf_rData.
- Read after write in later cycles needs no special handling; the register file holds the committed value.
- rspN_rdata holds its last captured value until that requester's next read completes.
- Reset (reset_n low at a rising edge), including mid-operation:
  - rr_ptr=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0.
  - Any in-flight response is discarded.
- While reset_n is low: req0_ready=req1_ready=0 and rf_we=0 (combinationally gated), so no register file write occurs during reset.
- Outputs after reset release: all zero until a request arrives.

Decomposition:
- Package rf_arb_pkg:
  - DATA_W/ADDR_W defaults.
  - Op encoding constants OP_READ=0, OP_WRITE=1.
  - Requester index constants REQ_A=0, REQ_B=1.
  - Typedef for the request bundle (valid, we, addr, wdata).
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: two request bits and rr_ptr.
  - Outputs: one-hot grant and a contended flag.
  - Instantiated once; the top level selects the write-contended or read-contended case.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with both valid (write) -> ready0=ready1=0, rf_we=0, rsp*_valid=0, rsp*_rdata=0.
- Single write then read: req0 write addr=3 data=0xDEADBEEF; next cycle req0 read addr=3 -> rf_we pulse with wAddr=3; rsp0_valid=1 one cycle after the read handshake with rsp0_rdata=0xDEADBEEF.
- Contention: req0 and req1 both write, held valid for 4 cycles (addr 1 / 2, data 0x11 / 0x22) -> grants alternate 0,1,0,1; rr_ptr toggles each cycle; rsp never asserts.
- Dual issue with bypass: reg5=0xAAAA5555; req0 write addr=5 data=0x12345678 and req1 read addr=5 in the same cycle -> both ready=1; next cycle rsp1_valid=1, rsp1_rdata=0x12345678; reg5 then reads 0x12345678.
- Dual issue, different addr: req1 write addr=2 and req0 read addr=6 (reg6=0x66) -> both ready; rsp0_rdata=0x66; rr_ptr unchanged.
- Reset mid-operation: accept a read from req1, assert reset_n=0 at the next edge -> rsp1_valid stays 0, rsp1_rdata=0, rr_ptr=0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants and request bundle type for the two-port register-file arbiter.
package rf_arb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: passes uncontended requests through, uses rr_ptr on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt,
  output logic       contended
);

  always_comb begin
    contended = req[0] & req[1];
    gnt       = req;
    if (contended) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register-file write port and one read port between requesters A and B,
// dual-issuing a write and a read when possible, round-robin otherwise.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData
);

  logic              v0, v1;
  logic [1:0]        wr_req, rd_req, arb_req, arb_gnt;
  logic [1:0]        wr_gnt, rd_gnt;
  logic              wr_cont, rd_cont, arb_cont;
  logic              rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q [2];
  logic [DATA_W-1:0] rsp_rdata_d [2];

  // Gating valids with reset keeps ready and rf_we low while reset is held.
  assign v0 = req0_valid & reset_n;
  assign v1 = req1_valid & reset_n;

  always_comb begin
    wr_req  = {v1 & (req1_we == OP_WRITE), v0 & (req0_we == OP_WRITE)};
    rd_req  = {v1 & (req1_we == OP_READ),  v0 & (req0_we == OP_READ)};
    wr_cont = &wr_req;
    rd_cont = &rd_req;
    arb_req = wr_cont ? wr_req : rd_req;
  end

  rr_arb2 u_rr_arb2 (
    .req       (arb_req),
    .rr_ptr    (rr_ptr_q),
    .gnt       (arb_gnt),
    .contended (arb_cont)
  );

  always_comb begin
    wr_gnt     = wr_cont ? arb_gnt : wr_req;
    rd_gnt     = rd_cont ? arb_gnt : rd_req;
    req0_ready = wr_gnt[REQ_A] | rd_gnt[REQ_A];
    req1_ready = wr_gnt[REQ_B] | rd_gnt[REQ_B];
    rr_ptr_d   = arb_cont ? arb_gnt[REQ_A] : rr_ptr_q;

    rf_we    = |wr_gnt;
    rf_wAddr = '0;
    rf_wData = '0;
    if (wr_gnt[REQ_B]) begin
      rf_wAddr = req1_addr;
      rf_wData = req1_wdata;
    end else if (wr_gnt[REQ_A]) begin
      rf_wAddr = req0_addr;
      rf_wData = req0_wdata;
    end

    rf_rAddr = '0;
    if (rd_gnt[REQ_B]) begin
      rf_rAddr = req1_addr;
    end else if (rd_gnt[REQ_A]) begin
      rf_rAddr = req0_addr;
    end

    // The file only commits at the edge, so a same-cycle read of the written address takes the new data.
    rd_data = (rf_we && (rf_wAddr == rf_rAddr)) ? rf_wData : rf_rData;

    rsp_valid_d    = rd_gnt;
    rsp_rdata_d[0] = rd_gnt[REQ_A] ? rd_data : rsp_rdata_q[0];
    rsp_rdata_d[1] = rd_gnt[REQ_B] ? rd_data : rsp_rdata_q[1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q       <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_rdata_q[0] <= '0;
      rsp_rdata_q[1] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q[0] <= rsp_rdata_d[0];
      rsp_rdata_q[1] <= rsp_rdata_d[1];
    end
  end

  assign rsp0_valid = rsp_valid_q[REQ_A];
  assign rsp1_valid = rsp_valid_q[REQ_B];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural 8x32 register file attached.
module tb_rf_port_arbiter;
  import rf_arb_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [2:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [2:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_rdata;
  logic        rf_we;
  logic [2:0]  rf_wAddr, rf_rAddr;
  logic [31:0] rf_wData, rf_rData;
  logic [31:0] rf_mem [8];

  int n_checks = 0;
  int n_errors = 0;

  rf_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rf_we      (rf_we),
    .rf_wAddr   (rf_wAddr),
    .rf_wData   (rf_wData),
    .rf_rAddr   (rf_rAddr),
    .rf_rData   (rf_rData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model; preload reg5/reg6 while reset is held.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        rf_mem[i] <= (i == 5) ? 32'hAAAA_5555 : (i == 6) ? 32'h0000_0066 : 32'h0;
      end
    end else if (rf_we) begin
      rf_mem[rf_wAddr] <= rf_wData;
    end
  end
  assign rf_rData = rf_mem[rf_rAddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input rf_req_t r0, input rf_req_t r1);
    req0_valid = r0.valid; req0_we = r0.we; req0_addr = r0.addr; req0_wdata = r0.wdata;
    req1_valid = r1.valid; req1_we = r1.we; req1_addr = r1.addr; req1_wdata = r1.wdata;
    #1;
  endtask

  localparam rf_req_t IDLE = '0;

  initial begin
    reset_n = 1'b0;
    drive('{1'b1, OP_WRITE, 3'd1, 32'h11}, '{1'b1, OP_WRITE, 3'd2, 32'h22});
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    tick();
    tick();
    check("rst_ready0_b", 32'(req0_ready), 0);
    check("rst_ready1_b", 32'(req1_ready), 0);
    check("rst_rf_we_b", 32'(rf_we), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_rsp0_rdata", rsp0_rdata, 0);
    check("rst_rsp1_rdata", rsp1_rdata, 0);
    check("rst_no_write", rf_mem[1], 0);

    reset_n = 1'b1;
    drive(IDLE, IDLE);
    check("idle_rf_we", 32'(rf_we), 0);
    check("idle_rAddr", 32'(rf_rAddr), 0);
    check("idle_wData", rf_wData, 0);
    tick();

    // single write then read-back
    drive('{1'b1, OP_WRITE, 3'd3, 32'hDEAD_BEEF}, IDLE);
    check("wr_ready0", 32'(req0_ready), 1);
    check("wr_rf_we", 32'(rf_we), 1);
    check("wr_wAddr", 32'(rf_wAddr), 3);
    check("wr_wData", rf_wData, 32'hDEAD_BEEF);
    tick();
    check("wr_no_rsp", 32'(rsp0_valid), 0);
    drive('{1'b0, OP_READ, 3'd3, 32'h0}, IDLE);
    req0_valid = 1'b1;
    #1;
    check("rd_ready0", 32'(req0_ready), 1);
    check("rd_rf_we", 32'(rf_we), 0);
    check("rd_wAddr", 32'(rf_wAddr), 0);
    check("rd_rAddr", 32'(rf_rAddr), 3);
    tick();
    drive(IDLE, IDLE);
    check("rd_rsp0_valid", 32'(rsp0_valid), 1);
    check("rd_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
    check("rd_rsp1_valid", 32'(rsp1_valid), 0);
    tick();
    check("rd_rsp0_pulse", 32'(rsp0_valid), 0);
    check("rd_rsp0_hold", rsp0_rdata, 32'hDEAD_BEEF);

    // contended writes alternate 0,1,0,1
    drive('{1'b1, OP_WRITE, 3'd1, 32'h11}, '{1'b1, OP_WRITE, 3'd2, 32'h22});
    for (int i = 0; i < 4; i++) begin
      check("ct_ready0", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
      check("ct_ready1", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
      check("ct_wAddr", 32'(rf_wAddr), (i % 2 == 0) ? 1 : 2);
      tick();
      check("ct_rr_ptr", 32'(dut.rr_ptr_q), (i % 2 == 0) ? 1 : 0);
      check("ct_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
    end
    check("ct_mem1", rf_mem[1], 32'h11);
    check("ct_mem2", rf_mem[2], 32'h22);

    // dual issue with same-address bypass
    drive('{1'b1, OP_WRITE, 3'd5, 32'h1234_5678}, '{1'b1, OP_READ, 3'd5, 32'h0});
    check("byp_ready0", 32'(req0_ready), 1);
    check("byp_ready1", 32'(req1_ready), 1);
    check("byp_rAddr", 32'(rf_rAddr), 5);
    check("byp_wAddr", 32'(rf_wAddr), 5);
    tick();
    drive('{1'b1, OP_READ, 3'd5, 32'h0}, IDLE);
    check("byp_rsp1_valid", 32'(rsp1_valid), 1);
    check("byp_rsp1_rdata", rsp1_rdata, 32'h1234_5678);
    check("byp_rsp0_valid", 32'(rsp0_valid), 0);
    check("byp_rr_ptr", 32'(dut.rr_ptr_q), 0);
    tick();
    drive(IDLE, IDLE);
    check("byp_reg5", rsp0_rdata, 32'h1234_5678);
    check("byp_reg5_valid", 32'(rsp0_valid), 1);

    // contended reads: A wins, pointer moves to B
    drive('{1'b1, OP_READ, 3'd1, 32'h0}, '{1'b1, OP_READ, 3'd2, 32'h0});
    check("cr_ready0", 32'(req0_ready), 1);
    check("cr_ready1", 32'(req1_ready), 0);
    tick();
    drive(IDLE, IDLE);
    check("cr_rsp0_rdata", rsp0_rdata, 32'h11);
    check("cr_rsp1_valid", 32'(rsp1_valid), 0);
    check("cr_rr_ptr", 32'(dut.rr_ptr_q), 1);

    // dual issue, different addresses, pointer must not move
    drive('{1'b1, OP_READ, 3'd6, 32'h0}, '{1'b1, OP_WRITE, 3'd2, 32'h2222});
    check("du_ready0", 32'(req0_ready), 1);
    check("du_ready1", 32'(req1_ready), 1);
    check("du_rAddr", 32'(rf_rAddr), 6);
    check("du_wData", rf_wData, 32'h2222);
    tick();
    drive(IDLE, IDLE);
    check("du_rsp0_rdata", rsp0_rdata, 32'h66);
    check("du_rsp1_valid", 32'(rsp1_valid), 0);
    check("du_rr_ptr", 32'(dut.rr_ptr_q), 1);
    check("du_mem2", rf_mem[2], 32'h2222);

    // reset while a response is in flight
    drive(IDLE, '{1'b1, OP_READ, 3'd6, 32'h0});
    check("mr_ready1", 32'(req1_ready), 1);
    tick();
    check("mr_rsp1_valid_pre", 32'(rsp1_valid), 1);
    reset_n = 1'b0;
    drive(IDLE, IDLE);
    tick();
    check("mr_rsp1_valid", 32'(rsp1_valid), 0);
    check("mr_rsp1_rdata", rsp1_rdata, 0);
    check("mr_rsp0_rdata", rsp0_rdata, 0);
    check("mr_rr_ptr", 32'(dut.rr_ptr_q), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
